// File: rtl/lsu_region_decoder.sv
// Registered LSU address decoder: matches each access against base/mask regions, forwards it to
// the single winning target, waits for that target's ack (or a timeout) and returns one response.
module lsu_region_decoder #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {32'h4000_0000, 32'h0000_7000, 32'h0000_2000, 32'h0000_7000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
        {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_FF00},
    parameter int TIMEOUT     = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_lsu_req,
    output logic                          o_lsu_ready,
    input  logic                          i_lsu_wren,
    input  logic [ADDR_W-1:0]             i_lsu_addr,
    input  logic [DATA_W-1:0]             i_lsu_wdata,
    output logic                          o_lsu_rvalid,
    output logic [DATA_W-1:0]             o_lsu_rdata,
    output logic                          o_lsu_err,
    output logic [NUM_REGIONS-1:0]        o_tgt_sel,
    output logic                          o_tgt_wren,
    output logic [ADDR_W-1:0]             o_tgt_addr,
    output logic [DATA_W-1:0]             o_tgt_wdata,
    input  logic [NUM_REGIONS-1:0]        i_tgt_ack,
    input  logic [NUM_REGIONS*DATA_W-1:0] i_tgt_rdata,
    output logic [1:0]                    o_dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_RESP     = 2'd2;
    localparam logic [1:0] ST_RESP_ERR = 2'd3;

    logic [1:0]             state;
    logic [CNT_W-1:0]       wait_cnt;
    logic [NUM_REGIONS-1:0] match;
    logic [NUM_REGIONS-1:0] win_sel;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   sel_ack;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            match[i] = (i_lsu_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                       (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]);
        end
    end

    // Isolating the lowest set bit resolves overlaps in favour of the lowest region index.
    assign win_sel = match & (~match + NUM_REGIONS'(1));

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (o_tgt_sel[i]) begin
                sel_rdata = sel_rdata | i_tgt_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ack     = |(i_tgt_ack & o_tgt_sel);
    assign o_lsu_ready = (state == ST_IDLE);
    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            o_lsu_rvalid <= 1'b0;
            o_lsu_err    <= 1'b0;
            o_lsu_rdata  <= '0;
            o_tgt_sel    <= '0;
            o_tgt_wren   <= 1'b0;
            o_tgt_addr   <= '0;
            o_tgt_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_lsu_req) begin
                        if (|match) begin
                            state       <= ST_ACCESS;
                            wait_cnt    <= '0;
                            o_tgt_sel   <= win_sel;
                            o_tgt_wren  <= i_lsu_wren;
                            o_tgt_addr  <= i_lsu_addr;
                            o_tgt_wdata <= i_lsu_wdata;
                        end else begin
                            state        <= ST_RESP_ERR;
                            o_lsu_rvalid <= 1'b1;
                            o_lsu_err    <= 1'b1;
                            o_lsu_rdata  <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack in the final wait cycle still completes the access normally.
                    if (sel_ack) begin
                        state        <= ST_RESP;
                        o_tgt_sel    <= '0;
                        o_lsu_rvalid <= 1'b1;
                        o_lsu_err    <= 1'b0;
                        o_lsu_rdata  <= o_tgt_wren ? '0 : sel_rdata;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state        <= ST_RESP_ERR;
                        o_tgt_sel    <= '0;
                        o_lsu_rvalid <= 1'b1;
                        o_lsu_err    <= 1'b1;
                        o_lsu_rdata  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    o_lsu_rvalid <= 1'b0;
                    o_lsu_err    <= 1'b0;
                    o_lsu_rdata  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_region_decoder.sv
// Bench for lsu_region_decoder: directed scenarios plus randomized accesses checked against a
// region-table model and an expected-response queue.
module tb_lsu_region_decoder;

    localparam int NR      = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    localparam logic [NR*AW-1:0] BASE_P = {32'h4000_0000, 32'h0000_7000, 32'h0000_2000, 32'h0000_7000};
    localparam logic [NR*AW-1:0] MASK_P = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_FF00};

    logic [AW-1:0] base_tbl [NR] = '{32'h0000_7000, 32'h0000_2000, 32'h0000_7000, 32'h4000_0000};
    logic [AW-1:0] mask_tbl [NR] = '{32'hFFFF_FF00, 32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_0000};

    logic           clk = 1'b0;
    logic           rst;
    logic           lsu_req;
    logic           lsu_ready;
    logic           lsu_wren;
    logic [AW-1:0]  lsu_addr;
    logic [DW-1:0]  lsu_wdata;
    logic           lsu_rvalid;
    logic [DW-1:0]  lsu_rdata;
    logic           lsu_err;
    logic [NR-1:0]  tgt_sel;
    logic           tgt_wren;
    logic [AW-1:0]  tgt_addr;
    logic [DW-1:0]  tgt_wdata;
    logic [NR-1:0]  tgt_ack;
    logic [NR*DW-1:0] tgt_rdata;
    logic [1:0]     dbg_state;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    lsu_region_decoder #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW),
        .REGION_BASE(BASE_P), .REGION_MASK(MASK_P), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_lsu_req(lsu_req), .o_lsu_ready(lsu_ready), .i_lsu_wren(lsu_wren),
        .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
        .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata), .o_lsu_err(lsu_err),
        .o_tgt_sel(tgt_sel), .o_tgt_wren(tgt_wren), .o_tgt_addr(tgt_addr),
        .o_tgt_wdata(tgt_wdata), .i_tgt_ack(tgt_ack), .i_tgt_rdata(tgt_rdata),
        .o_dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First region in table order whose masked base equals the masked address; -1 when none.
    function automatic int model_region(input logic [AW-1:0] addr);
        for (int i = 0; i < NR; i++) begin
            if ((addr & mask_tbl[i]) == (base_tbl[i] & mask_tbl[i])) return i;
        end
        return -1;
    endfunction

    task automatic scramble_rdata();
        for (int i = 0; i < NR; i++) tgt_rdata[i*DW +: DW] = $urandom;
    endtask

    // Driver: issue one access, play the target side, and check the response.
    // delay = index of the selected-target cycle in which the ack is returned.
    task automatic run_txn(input logic wren, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int delay, input logic [DW-1:0] data, input bit stray);
        int r;
        logic [NR-1:0] exp_sel;
        int exp_sel_cycles;
        logic exp_err;
        int sel_cycles;
        int guard;
        bit got;
        logic [DW-1:0] exp_rdata;

        r = model_region(addr);
        exp_sel = (r >= 0) ? NR'(1 << r) : '0;
        if (r < 0) begin
            exp_err = 1'b1; exp_sel_cycles = 0; exp_q.push_back('0);
        end else if (delay <= TIMEOUT) begin
            exp_err = 1'b0; exp_sel_cycles = delay; exp_q.push_back(wren ? '0 : data);
        end else begin
            exp_err = 1'b1; exp_sel_cycles = TIMEOUT; exp_q.push_back('0);
        end

        guard = 0;
        while (!lsu_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", lsu_ready, 1);

        lsu_req = 1'b1; lsu_wren = wren; lsu_addr = addr; lsu_wdata = wdata;
        @(negedge clk);
        lsu_req = 1'b0; lsu_wren = 1'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;

        got = 1'b0;
        sel_cycles = 0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            tgt_ack = '0;
            scramble_rdata();
            if (lsu_rvalid) begin
                got = 1'b1;
                exp_rdata = exp_q.pop_front();
                check("rsp_rdata", lsu_rdata, exp_rdata);
                check("rsp_err", lsu_err, exp_err);
                check("sel_cycles", sel_cycles, exp_sel_cycles);
                check("rsp_latency", cyc, exp_sel_cycles + 1);
                check("sel_clear_at_rsp", tgt_sel, 0);
                check("ready_low_at_rsp", lsu_ready, 0);
            end else begin
                if (tgt_sel != '0) begin
                    sel_cycles++;
                    check("tgt_sel", tgt_sel, exp_sel);
                    if (sel_cycles == 1) begin
                        check("tgt_addr", tgt_addr, addr);
                        check("tgt_wren", tgt_wren, wren);
                        check("tgt_wdata", tgt_wdata, wdata);
                    end
                    if (sel_cycles == delay) begin
                        tgt_ack = exp_sel;
                        tgt_rdata[r*DW +: DW] = data;
                    end else if (stray) begin
                        tgt_ack = ~exp_sel & NR'($urandom);
                    end
                end
                @(negedge clk);
            end
        end
        tgt_ack = '0;
        if (!got) begin
            check("rsp_seen", 0, 1);
            void'(exp_q.pop_front());
        end else begin
            @(negedge clk);
            check("rvalid_one_cycle", lsu_rvalid, 0);
            check("ready_after_rsp", lsu_ready, 1);
        end
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_ready"}, lsu_ready, 1);
        check({tag, "_rvalid"}, lsu_rvalid, 0);
        check({tag, "_err"}, lsu_err, 0);
        check({tag, "_rdata"}, lsu_rdata, 0);
        check({tag, "_sel"}, tgt_sel, 0);
        check({tag, "_twren"}, tgt_wren, 0);
        check({tag, "_taddr"}, tgt_addr, 0);
        check({tag, "_twdata"}, tgt_wdata, 0);
    endtask

    initial begin
        int kind;
        logic [AW-1:0] a;

        rst = 1'b1; lsu_req = 1'b0; lsu_wren = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        tgt_ack = '0; tgt_rdata = '0;
        repeat (3) @(negedge clk);
        check_all_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_txn(1'b0, 32'h0000_2010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        run_txn(1'b1, 32'h0000_7004, 32'h55, 2, 32'hCAFE_F00D, 1'b0);
        run_txn(1'b0, 32'h0000_9000, 32'h0, 1, 32'h1234_5678, 1'b0);
        run_txn(1'b0, 32'h0000_2100, 32'h0, 99, 32'h1111_1111, 1'b0);
        run_txn(1'b0, 32'h0000_7000, 32'h0, 4, 32'hA5A5_5A5A, 1'b1);
        run_txn(1'b0, 32'h0000_7080, 32'h0, TIMEOUT, 32'h0BAD_CAFE, 1'b1);
        run_txn(1'b0, 32'h0000_7100, 32'h0, 1, 32'h7777_0002, 1'b0);
        run_txn(1'b1, 32'h4000_0010, 32'h99, TIMEOUT + 1, 32'h0, 1'b0);

        // Reset in the middle of an access: no response, late ack ignored.
        lsu_req = 1'b1; lsu_wren = 1'b0; lsu_addr = 32'h0000_2010;
        @(negedge clk);
        lsu_req = 1'b0;
        check("mid_sel", tgt_sel, 4'b0010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_idle("mid_reset");
        rst = 1'b0;
        tgt_ack = 4'b0010;
        tgt_rdata[1*DW +: DW] = 32'hFEED_FACE;
        @(negedge clk);
        tgt_ack = '0;
        for (int k = 0; k < 4; k++) begin
            check("late_ack_no_rvalid", lsu_rvalid, 0);
            @(negedge clk);
        end

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: a = 32'h0000_2000 + $urandom_range(0, 32'h1FFF);
                1: a = 32'h0000_7000 + $urandom_range(0, 32'hFF);
                2: a = 32'h0000_7100 + $urandom_range(0, 32'hEFF);
                3: a = 32'h4000_0000 + $urandom_range(0, 32'hFFFF);
                default: a = $urandom;
            endcase
            run_txn(1'($urandom), a, $urandom, $urandom_range(1, TIMEOUT + 2), $urandom,
                    1'($urandom));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
